// File: rtl/psmac_pkg.sv
// Shared types for the precision-scalable MAC sequencer: FSM states, precision
// encodings and the digit-count helper.
package psmac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [1:0] PREC_2 = 2'd0;
  localparam logic [1:0] PREC_4 = 2'd1;
  localparam logic [1:0] PREC_8 = 2'd2;

  // Encoding 3 is treated as 8-bit.
  function automatic logic [3:0] digits_for_prec(input logic [1:0] prec);
    case (prec)
      PREC_2:  return 4'd1;
      PREC_4:  return 4'd2;
      PREC_8:  return 4'd4;
      default: return 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/psmac_seq_ctrl_if.sv
// Operand/result handshake bundle between operand fetch, the MAC sequencer
// and result writeback.
interface psmac_seq_ctrl_if #(
  parameter int W     = 8,
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             signed_a;
  logic             signed_b;
  logic [1:0]       prec;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             busy;
  logic             sat;

  modport master (
    output in_valid, a, b, signed_a, signed_b, prec, acc_clr, out_ready,
    input  in_ready, out_valid, acc_out, busy, sat
  );

  modport slave (
    input  in_valid, a, b, signed_a, signed_b, prec, acc_clr, out_ready,
    output in_ready, out_valid, acc_out, busy, sat
  );
endinterface

// File: rtl/psmac_digit_mul.sv
// Combinational 2x2-bit signed-digit multiplier; sx/sy mark a digit as the
// sign-carrying top digit of its operand.
module psmac_digit_mul (
  input  logic [1:0] md,
  input  logic [1:0] mr,
  input  logic       sx,
  input  logic       sy,
  output logic [4:0] p
);
  logic signed [2:0] x_s;
  logic signed [2:0] y_s;
  logic signed [4:0] prod_s;

  // Range is -6..9, so a 5-bit product is exact.
  always_comb begin
    x_s    = $signed({sx & md[1], md});
    y_s    = $signed({sy & mr[1], mr});
    prod_s = 5'(x_s) * 5'(y_s);
    p      = prod_s;
  end
endmodule

// File: rtl/psmac_seq_ctrl.sv
// Sequential precision-scalable MAC controller: iterates digit pairs through one
// shared digit multiplier. Optional saturating accumulate: PSMAC_ACC_SAT_EN.
module psmac_seq_ctrl
  import psmac_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 24
) (
  input logic              clk,
  input logic              rst_n,
  psmac_seq_ctrl_if.slave  bus
);
  localparam int PW   = 2 * W + 1;
  localparam int HALF = W / 2;
  localparam int NW   = $clog2(HALF + 1);

  state_t                   state_r, state_nxt_s;
  logic [W-1:0]             a_r, b_r;
  logic                     sa_r, sb_r, clr_r;
  logic [NW-1:0]            nd_r, i_r, j_r, nd_s;
  logic [3:0]               nd_raw_s;
  logic signed [PW-1:0]     prod_r, dp_ext_s, term_s;
  logic signed [ACC_W-1:0]  acc_r, acc_nxt_s;
  logic [1:0]               md_s, mr_s;
  logic                     sx_s, sy_s, last_i_s, last_j_s, accept_s;
  logic [4:0]               dp_s;
  logic [NW:0]              ij_s;
  logic [NW+1:0]            sh_s;

  assign accept_s = bus.in_valid && (state_r == IDLE);
  assign last_i_s = (i_r == nd_r - NW'(1));
  assign last_j_s = (j_r == nd_r - NW'(1));
  assign md_s     = a_r[{i_r, 1'b0} +: 2];
  assign mr_s     = b_r[{j_r, 1'b0} +: 2];
  assign sx_s     = sa_r && last_i_s;
  assign sy_s     = sb_r && last_j_s;

  psmac_digit_mul u_digit_mul (
    .md (md_s),
    .mr (mr_s),
    .sx (sx_s),
    .sy (sy_s),
    .p  (dp_s)
  );

  // Digit count for the incoming precision, limited to what W can hold.
  always_comb begin
    nd_raw_s = digits_for_prec(bus.prec);
    if (int'(nd_raw_s) > HALF) nd_s = NW'(HALF);
    else                       nd_s = NW'(nd_raw_s);
    ij_s     = {1'b0, i_r} + {1'b0, j_r};
    sh_s     = {ij_s, 1'b0};
    dp_ext_s = PW'($signed(dp_s));
    term_s   = dp_ext_s << sh_s;
  end

`ifdef PSMAC_ACC_SAT_EN
  logic                    sat_r;
  logic                    ovf_s;
  logic signed [ACC_W:0]   sum_s, base_s;

  // One guard bit exposes signed overflow; clamp to the representable extreme.
  always_comb begin
    if (clr_r) base_s = '0;
    else       base_s = (ACC_W + 1)'(acc_r);
    sum_s = base_s + (ACC_W + 1)'(prod_r);
    ovf_s = (sum_s[ACC_W] != sum_s[ACC_W-1]);
    if (ovf_s) begin
      if (sum_s[ACC_W]) acc_nxt_s = {1'b1, {(ACC_W-1){1'b0}}};
      else              acc_nxt_s = {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_nxt_s = sum_s[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            sat_r <= 1'b0;
    else if (accept_s && bus.acc_clr)      sat_r <= 1'b0;
    else if (state_r == ACC && ovf_s)      sat_r <= 1'b1;
    else                                   sat_r <= sat_r;
  end

  assign bus.sat = sat_r;
`else
  logic signed [ACC_W-1:0] base_s;

  always_comb begin
    if (clr_r) base_s = '0;
    else       base_s = acc_r;
    acc_nxt_s = base_s + ACC_W'(prod_r);
  end

  assign bus.sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_nxt_s = MUL; else state_nxt_s = IDLE;
      MUL:     if (last_i_s && last_j_s) state_nxt_s = ACC; else state_nxt_s = MUL;
      ACC:     state_nxt_s = OUT;
      OUT:     if (bus.out_ready) state_nxt_s = IDLE; else state_nxt_s = OUT;
      default: state_nxt_s = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_r == IDLE);
    bus.out_valid = (state_r == OUT);
    bus.busy      = (state_r != IDLE);
  end

  assign bus.acc_out = acc_r;

  // Operand latch, digit-pair iteration and accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0; b_r <= '0; sa_r <= 1'b0; sb_r <= 1'b0; clr_r <= 1'b0;
      nd_r <= '0; i_r <= '0; j_r <= '0; prod_r <= '0; acc_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r <= bus.a; b_r <= bus.b;
            sa_r <= bus.signed_a; sb_r <= bus.signed_b; clr_r <= bus.acc_clr;
            nd_r <= nd_s; i_r <= '0; j_r <= '0; prod_r <= '0;
          end
        end
        MUL: begin
          prod_r <= prod_r + term_s;
          if (last_j_s) begin
            j_r <= '0;
            i_r <= i_r + NW'(1);
          end else begin
            j_r <= j_r + NW'(1);
          end
        end
        ACC:     acc_r <= acc_nxt_s;
        default: acc_r <= acc_r;
      endcase
    end
  end
endmodule

// File: tb/tb_psmac_seq_ctrl.sv
// Scoreboard bench for psmac_seq_ctrl: directed transactions push expected results,
// a negedge monitor checks them. Build with PSMAC_ACC_SAT_EN for the saturation case.
module tb_psmac_seq_ctrl;
`ifdef PSMAC_ACC_SAT_EN
  localparam int ACC_W = 17;
`else
  localparam int ACC_W = 24;
`endif
  localparam int W = 8;

  typedef struct packed {
    logic [23:0] acc;
    logic        sat;
    logic [7:0]  lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   edge_count = 0;
  int   accept_edge = 0;
  int   meas_lat = 0;
  logic prev_ov = 1'b0;

  always #5 clk = ~clk;

  psmac_seq_ctrl_if #(.W(W), .ACC_W(ACC_W)) bus ();

  psmac_seq_ctrl #(.W(W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) edge_count <= edge_count + 1;

  // Monitor: records accept edge, measures latency, pops and compares results.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) accept_edge = edge_count + 1;
      if (bus.out_valid && !prev_ov) meas_lat = edge_count - accept_edge;
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: acc_out=0x%0h with empty scoreboard", bus.acc_out);
        end else begin
          e = sb_q.pop_front();
          check("acc_out", 32'(bus.acc_out), 32'(e.acc[ACC_W-1:0]));
          check("sat", 32'(bus.sat), 32'(e.sat));
          check("latency", 32'(meas_lat), 32'(e.lat));
        end
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic issue(input logic [1:0] p, input logic [7:0] aa, input logic [7:0] bb,
                       input logic sa, input logic sb, input logic clr, input logic push_it,
                       input logic [23:0] ea, input logic es, input int lat);
    exp_t e;
    int k;
    @(posedge clk); #1;
    bus.prec = p; bus.a = aa; bus.b = bb;
    bus.signed_a = sa; bus.signed_b = sb; bus.acc_clr = clr;
    bus.in_valid = 1'b1;
    if (push_it) begin
      e.acc = ea; e.sat = es; e.lat = 8'(lat);
      sb_q.push_back(e);
    end
    k = 0;
    while (!bus.in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", k);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (bus.busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", bus.busy, k);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.in_valid = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.signed_a = 1'b0;
    bus.signed_b = 1'b0; bus.prec = 2'd0; bus.acc_clr = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_acc_out", 32'(bus.acc_out), 32'd0);
    check("rst_sat", 32'(bus.sat), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(2'd2, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 24'h00FE01, 1'b0, 17); wait_idle();
    issue(2'd2, 8'h80, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFFC080, 1'b0, 17); wait_idle();
    issue(2'd0, 8'hA2, 8'hF3, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000002, 1'b0, 2);  wait_idle();
    issue(2'd1, 8'hF7, 8'hF7, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000031, 1'b0, 5);  wait_idle();
    issue(2'd1, 8'hF8, 8'hF7, 1'b1, 1'b1, 1'b0, 1'b1, 24'hFFFFF9, 1'b0, 5);  wait_idle();
    issue(2'd3, 8'h10, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000100, 1'b0, 17); wait_idle();

    // Backpressure: result held in OUT while a new operand waits.
    bus.out_ready = 1'b0;
    issue(2'd1, 8'h02, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000006, 1'b0, 5);
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.a = 8'h05; bus.b = 8'h05; bus.acc_clr = 1'b1; bus.prec = 2'd1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_acc_out", 32'(bus.acc_out), 32'd6);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();
    @(negedge clk);
    check("bp_no_accept", 32'(bus.busy), 32'd0);
    check("bp_acc_hold", 32'(bus.acc_out), 32'd6);

    // Reset during the fifth MUL cycle aborts the transaction.
    issue(2'd2, 8'h05, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 17);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_acc_out", 32'(bus.acc_out), 32'd0);
    check("mid_rst_sat", 32'(bus.sat), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(2'd1, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000009, 1'b0, 5); wait_idle();

`ifdef PSMAC_ACC_SAT_EN
    for (int n = 0; n < 4; n++) begin
      issue(2'd2, 8'h7F, 8'h7F, 1'b1, 1'b1, (n == 0), 1'b1, 24'(16129 * (n + 1)), 1'b0, 17);
      wait_idle();
    end
    issue(2'd2, 8'h7F, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 24'h00FFFF, 1'b1, 17); wait_idle();
    issue(2'd2, 8'h01, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000001, 1'b0, 17); wait_idle();
`endif

    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
